// File: rtl/atm_pkg.sv
// Shared definitions for the ATM frame writer: FSM encoding, FIFO word layout,
// and the one-hot channel-select decode used to qualify ADC results.
package atm_pkg;

  // Width of the channel-select bus and of the encoded channel index.
  localparam int SEL_W  = 8;
  localparam int CHAN_W = 3;

  // FIFO word layout, expressed as bit offsets above the top of the data field:
  // word = {chan[CHAN_W-1:0], last, data[DATA_W-1:0]}.
  localparam int LAST_BIT = 0;
  localparam int CHAN_LSB = 1;

  // Extra bits the FIFO word carries on top of the ADC data.
  localparam int TAG_W = CHAN_LSB + CHAN_W;

  // Frame writer control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2,
    ST_DROP = 2'd3
  } atm_state_e;

  // Result of decoding a channel-select vector.
  typedef struct packed {
    logic              valid;
    logic [CHAN_W-1:0] index;
  } onehot_t;

  // Exactly one bit set -> valid, index = position of that bit.
  // Zero or multi-hot vectors are flagged invalid; the index is then meaningless.
  function automatic onehot_t onehot_decode(input logic [SEL_W-1:0] sel);
    onehot_t res;
    res.valid = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
    res.index = 3'd0;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel[i]) begin
        res.index = res.index | i[CHAN_W-1:0];
      end else begin
        res.index = res.index;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/atm_onehot_enc.sv
// One-hot channel select to binary index, with a validity flag that rejects
// zero and multi-hot selects.
module atm_onehot_enc
  import atm_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  output logic [CHAN_W-1:0] index,
  output logic              valid
);

  onehot_t dec_s;

  // Decode the select vector through the shared package function.
  always_comb begin
    dec_s = onehot_decode(sel);
    index = dec_s.index;
    valid = dec_s.valid;
  end

endmodule

// File: rtl/atm_frame_writer.sv
// ATM frame writer: forwards tagged ADC results into a downstream FIFO,
// only starting on a frame boundary and discarding the remainder of any frame
// in which a word was lost to a full FIFO. Tracks a sticky overflow flag and a
// saturating count of damaged frames.
module atm_frame_writer
  import atm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic                SAMPLE_CLK,
  input  logic                NRST_sync,
  input  logic                ENSAMP_sync,
  input  logic                DONE,
  input  logic [DATA_W-1:0]   ADC_DATA,
  input  logic [SEL_W-1:0]    ATMCHSEL_DATA,
  input  logic                LASTWORD,
  input  logic                FIFO_FULL,
  output logic                FIFO_WR,
  output logic [DATA_W+3:0]   FIFO_WDATA,
  input  logic                OVF_CLR,
  output logic                OVF,
  output logic [CNT_W-1:0]    DROP_CNT
);

  localparam int                WORD_W  = DATA_W + TAG_W;
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  atm_state_e         state_r;
  atm_state_e         state_nxt_s;

  logic [CHAN_W-1:0]  chan_s;
  logic               sel_ok_s;
  logic               valid_s;
  logic               frame_end_s;

  logic               wr_en_s;
  logic               drop_s;
  logic [WORD_W-1:0]  word_s;

  logic               fifo_wr_r;
  logic [WORD_W-1:0]  fifo_wdata_r;
  logic               ovf_r;
  logic [CNT_W-1:0]   drop_cnt_r;

  atm_onehot_enc u_onehot_enc (
    .sel   (ATMCHSEL_DATA),
    .index (chan_s),
    .valid (sel_ok_s)
  );

  // Qualify the conversion strobe: only one-hot selects count as results.
  always_comb begin
    valid_s     = DONE & sel_ok_s;
    frame_end_s = valid_s & LASTWORD;
  end

  // Assemble the FIFO word from the result presented alongside DONE.
  always_comb begin
    word_s                              = {WORD_W{1'b0}};
    word_s[DATA_W-1:0]                  = ADC_DATA;
    word_s[DATA_W+LAST_BIT]             = LASTWORD;
    word_s[DATA_W+CHAN_LSB +: CHAN_W]   = chan_s;
  end

  // State register; asynchronous reset returns to IDLE so re-entry goes via SYNC.
  always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: losing the enable always wins; otherwise realign on frame ends.
  always_comb begin
    state_nxt_s = state_r;
    if (!ENSAMP_sync) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_SYNC;
        end
        ST_SYNC: begin
          if (frame_end_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_SYNC;
          end
        end
        ST_RUN: begin
          // A word lost mid-frame poisons the rest of that frame.
          if (valid_s && FIFO_FULL && !LASTWORD) begin
            state_nxt_s = ST_DROP;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DROP: begin
          if (frame_end_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_DROP;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Per-result actions: write when the FIFO has room, record a drop when not.
  // Only RUN acts on results; SYNC and DROP merely watch for frame ends.
  always_comb begin
    wr_en_s = 1'b0;
    drop_s  = 1'b0;
    if (ENSAMP_sync && valid_s) begin
      case (state_r)
        ST_RUN: begin
          wr_en_s = ~FIFO_FULL;
          drop_s  = FIFO_FULL;
        end
        ST_IDLE, ST_SYNC, ST_DROP: begin
          wr_en_s = 1'b0;
          drop_s  = 1'b0;
        end
        default: begin
          wr_en_s = 1'b0;
          drop_s  = 1'b0;
        end
      endcase
    end else begin
      wr_en_s = 1'b0;
      drop_s  = 1'b0;
    end
  end

  // Registered FIFO interface: one-cycle write pulse, data held between writes.
  always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      fifo_wr_r    <= 1'b0;
      fifo_wdata_r <= {WORD_W{1'b0}};
    end else begin
      fifo_wr_r <= wr_en_s;
      if (wr_en_s) begin
        fifo_wdata_r <= word_s;
      end else begin
        fifo_wdata_r <= fifo_wdata_r;
      end
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear.
  always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (OVF_CLR) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Damaged-frame counter; only the first drop of a frame reaches here because
  // DROP swallows the rest of the frame. Saturates at all-ones.
  always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (drop_s && (drop_cnt_r != CNT_MAX)) begin
      drop_cnt_r <= drop_cnt_r + CNT_ONE;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign FIFO_WR    = fifo_wr_r;
  assign FIFO_WDATA = fifo_wdata_r;
  assign OVF        = ovf_r;
  assign DROP_CNT   = drop_cnt_r;

endmodule

// File: tb/tb_atm_frame_writer.sv
// Self-checking bench for atm_frame_writer: a frame-level reference model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_atm_frame_writer;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int WORD_W = DATA_W + 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ens = 1'b0;
  logic              done = 1'b0;
  logic [DATA_W-1:0] adc = 16'h0000;
  logic [7:0]        sel = 8'h00;
  logic              last = 1'b0;
  logic              full = 1'b0;
  logic              ovf_clr = 1'b0;

  logic              fifo_wr;
  logic [WORD_W-1:0] fifo_wdata;
  logic              ovf;
  logic [CNT_W-1:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model outputs and frame-tracking flags.
  logic              m_wr;
  logic [WORD_W-1:0] m_wdata;
  logic              m_ovf;
  logic [CNT_W-1:0]  m_cnt;
  bit                m_armed;
  bit                m_aligned;
  bit                m_discard;

  logic [WORD_W-1:0] wlog[$];

  atm_frame_writer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .SAMPLE_CLK    (clk),
    .NRST_sync     (rst_n),
    .ENSAMP_sync   (ens),
    .DONE          (done),
    .ADC_DATA      (adc),
    .ATMCHSEL_DATA (sel),
    .LASTWORD      (last),
    .FIFO_FULL     (full),
    .FIFO_WR       (fifo_wr),
    .FIFO_WDATA    (fifo_wdata),
    .OVF_CLR       (ovf_clr),
    .OVF           (ovf),
    .DROP_CNT      (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: enabled -> one cycle armed -> wait for a frame end ->
  // write whole frames; a full FIFO loses the word, flags it, and the rest of
  // that frame is thrown away.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr      <= 1'b0;
      m_wdata   <= '0;
      m_ovf     <= 1'b0;
      m_cnt     <= '0;
      m_armed   <= 1'b0;
      m_aligned <= 1'b0;
      m_discard <= 1'b0;
    end else begin
      bit ok;
      bit set_ovf;
      int ch;
      set_ovf = 1'b0;
      ok = done && ($countones(sel) == 1);
      ch = 0;
      for (int i = 0; i < 8; i++) if (sel == (8'd1 << i)) ch = i;
      m_wr <= 1'b0;
      if (!ens) begin
        m_armed   <= 1'b0;
        m_aligned <= 1'b0;
        m_discard <= 1'b0;
      end else if (!m_armed) begin
        m_armed <= 1'b1;
      end else if (ok) begin
        if (!m_aligned) m_aligned <= last;
        else if (m_discard) m_discard <= !last;
        else if (!full) begin
          m_wr    <= 1'b1;
          m_wdata <= {ch[2:0], last, adc};
        end else begin
          set_ovf = 1'b1;
          if (m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
          m_discard <= !last;
        end
      end
      if (set_ovf) m_ovf <= 1'b1;
      else if (ovf_clr) m_ovf <= 1'b0;
    end
  end

  // Compare every output against the model each cycle and log DUT writes.
  always @(negedge clk) begin
    chk("fifo_wr", fifo_wr, m_wr);
    chk("fifo_wdata", fifo_wdata, m_wdata);
    chk("ovf", ovf, m_ovf);
    chk("drop_cnt", drop_cnt, m_cnt);
    if (fifo_wr === 1'b1) wlog.push_back(fifo_wdata);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One result cycle followed by one quiet cycle.
  task automatic put(input logic [7:0] s, input logic l, input logic [15:0] d, input logic f);
    done = 1'b1; sel = s; last = l; adc = d; full = f;
    tick();
    done = 1'b0; sel = 8'h00; last = 1'b0; full = 1'b0;
    tick();
  endtask

  // Frame of channels {0,1,3}; fm[k] makes the FIFO full for the k-th word.
  task automatic frame(input logic [15:0] base, input logic [2:0] fm);
    put(8'h01, 1'b0, base,          fm[0]);
    put(8'h02, 1'b0, base + 16'd1,  fm[1]);
    put(8'h08, 1'b1, base + 16'd3,  fm[2]);
  endtask

  initial begin
    int n0;
    repeat (3) tick();
    chk("rst_wr", fifo_wr, 1'b0);
    chk("rst_wdata", fifo_wdata, 20'h00000);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_cnt", drop_cnt, 8'h00);
    rst_n = 1'b1;
    tick();

    // Enable mid-frame: the tail of the current frame is skipped.
    ens = 1'b1;
    tick();
    put(8'h02, 1'b0, 16'h0E01, 1'b0);
    put(8'h08, 1'b1, 16'h0E03, 1'b0);
    n0 = wlog.size();
    chk("sync_nowrite", n0, 0);
    frame(16'h1000, 3'b000);
    chk("f1_count", wlog.size() - n0, 3);
    chk("f1_w0", wlog[n0],     20'h01000);
    chk("f1_w1", wlog[n0 + 1], 20'h21001);
    chk("f1_w2", wlog[n0 + 2], 20'h71003);

    // Full FIFO on channel 1: rest of frame dropped, next frame whole.
    n0 = wlog.size();
    frame(16'h2000, 3'b010);
    chk("f2_ovf", ovf, 1'b1);
    chk("f2_cnt", drop_cnt, 8'd1);
    frame(16'h3000, 3'b000);
    chk("f2_count", wlog.size() - n0, 4);
    chk("f2_w0", wlog[n0],     20'h02000);
    chk("f2_w1", wlog[n0 + 1], 20'h03000);

    // Full FIFO only on the last word: stays aligned.
    n0 = wlog.size();
    frame(16'h4000, 3'b100);
    chk("f3_cnt", drop_cnt, 8'd2);
    frame(16'h5000, 3'b000);
    chk("f3_count", wlog.size() - n0, 5);
    chk("f3_w4", wlog[n0 + 4], 20'h75003);

    // Overflow clear versus simultaneous set.
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_alone", ovf, 1'b0);
    done = 1'b1; sel = 8'h08; last = 1'b1; adc = 16'h5555; full = 1'b1; ovf_clr = 1'b1;
    tick();
    done = 1'b0; sel = 8'h00; last = 1'b0; full = 1'b0; ovf_clr = 1'b0;
    chk("set_wins", ovf, 1'b1);
    chk("set_wins_cnt", drop_cnt, 8'd3);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_after", ovf, 1'b0);
    chk("clr_cnt_kept", drop_cnt, 8'd3);

    // Zero and multi-hot selects are ignored.
    n0 = wlog.size();
    put(8'h00, 1'b1, 16'hDEAD, 1'b0);
    put(8'h03, 1'b1, 16'hBEEF, 1'b0);
    put(8'h03, 1'b0, 16'hBEEF, 1'b1);
    chk("bad_sel_nowrite", wlog.size() - n0, 0);
    chk("bad_sel_cnt", drop_cnt, 8'd3);
    frame(16'h6000, 3'b000);
    chk("bad_sel_still_run", wlog.size() - n0, 3);

    // Counter saturation.
    repeat (256) put(8'h08, 1'b1, 16'h7000, 1'b1);
    chk("sat_cnt", drop_cnt, 8'hFF);
    chk("sat_model", m_cnt, 8'hFF);
    chk("sat_ovf", ovf, 1'b1);

    // Enable dropped on a result cycle mid-frame.
    put(8'h01, 1'b0, 16'h8000, 1'b0);
    done = 1'b1; sel = 8'h02; adc = 16'h8001; ens = 1'b0;
    tick();
    done = 1'b0; sel = 8'h00;
    chk("dis_nowrite", fifo_wr, 1'b0);
    tick();
    ens = 1'b1;
    tick();
    chk("dis_ovf_kept", ovf, 1'b1);
    chk("dis_cnt_kept", drop_cnt, 8'hFF);
    n0 = wlog.size();
    put(8'h08, 1'b1, 16'h8003, 1'b0);
    frame(16'h9000, 3'b000);
    chk("dis_count", wlog.size() - n0, 3);
    chk("dis_w0", wlog[n0], 20'h09000);

    // Reset with a write just issued.
    done = 1'b1; sel = 8'h01; adc = 16'hA000;
    tick();
    done = 1'b0; sel = 8'h00;
    rst_n = 1'b0;
    #1;
    chk("arst_wr", fifo_wr, 1'b0);
    chk("arst_wdata", fifo_wdata, 20'h00000);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_cnt", drop_cnt, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    n0 = wlog.size();
    put(8'h02, 1'b0, 16'hB001, 1'b0);
    put(8'h08, 1'b1, 16'hB003, 1'b0);
    frame(16'hC000, 3'b000);
    chk("rst_count", wlog.size() - n0, 3);
    chk("rst_w2", wlog[n0 + 2], 20'h7C003);
    chk("rst_model_ovf", m_ovf, 1'b0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
